// File: rtl/sys_array_pkg.sv
// Shared types and sizing helpers for the systolic array sequencer.
package sys_array_pkg;

  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_FEED, S_DONE} state_e;

  function automatic int row_w(input int max_rows);
    return (max_rows > 1) ? $clog2(max_rows) : 1;
  endfunction

  function automatic int cnt_w(input int max_rows);
    return $clog2(max_rows + 1);
  endfunction

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter wide enough for the last feed step, M + 2N - 2.
  function automatic int t_w(input int n, input int max_rows);
    return $clog2(max_rows + 2 * n);
  endfunction

  function automatic int load_len(input int n);
    return n;
  endfunction

  function automatic int feed_len(input int n, input int m);
    return m + 2 * n - 1;
  endfunction

endpackage

// File: rtl/sys_array_skew_gen.sv
// One skewed lane: enabled for OFFSET <= t < OFFSET+M, address is t-OFFSET.
module sys_array_skew_gen #(
  parameter int OFFSET = 0,
  parameter int T_W    = 5,
  parameter int CNT_W  = 5,
  parameter int ROW_W  = 4
) (
  input  logic [T_W-1:0]   t_i,
  input  logic [CNT_W-1:0] m_i,
  output logic             en_o,
  output logic [ROW_W-1:0] addr_o
);

  localparam int W = ((T_W > CNT_W) ? T_W : CNT_W) + 1;

  logic [W-1:0] tq, lo, hi;

  assign tq     = W'(t_i);
  assign lo     = W'(OFFSET);
  assign hi     = lo + W'(m_i);
  assign en_o   = (tq >= lo) && (tq < hi);
  assign addr_o = en_o ? ROW_W'(tq - lo) : '0;

endmodule

// File: rtl/sys_array_ctrl.sv
// Weight-stationary systolic array sequencer: row-wise weight load, skewed input feed, result strobes.
// Optional SYS_ARRAY_CTRL_WEIGHT_REUSE_EN: reuse_weights_i on start skips the weight load.
module sys_array_ctrl
  import sys_array_pkg::*;
#(
  parameter  int ARRAY_SIZE = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_ROWS   = 16,
  localparam int ROW_W      = row_w(MAX_ROWS),
  localparam int CNT_W      = cnt_w(MAX_ROWS),
  localparam int WA_W       = addr_w(ARRAY_SIZE)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        start_i,
  input  logic [CNT_W-1:0]            num_rows_i,
  input  logic                        reuse_weights_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [ARRAY_SIZE-1:0]       weight_load_o,
  output logic [WA_W-1:0]             weight_rd_addr_o,
  output logic [ARRAY_SIZE-1:0]       in_row_en_o,
  output logic [ARRAY_SIZE*ROW_W-1:0] in_rd_addr_o,
  output logic [ARRAY_SIZE-1:0]       out_col_valid_o,
  output logic [ARRAY_SIZE*ROW_W-1:0] out_wr_addr_o
);

  localparam int T_W      = t_w(ARRAY_SIZE, MAX_ROWS);
  localparam int LOAD_LEN = load_len(ARRAY_SIZE);
  localparam int unused_data_w = DATA_WIDTH;

  state_e           state_q, state_d;
  logic [T_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] m_q, m_d;
  logic [T_W-1:0]   feed_last;
  logic             go_feed;

`ifdef SYS_ARRAY_CTRL_WEIGHT_REUSE_EN
  assign go_feed = reuse_weights_i;
`else
  logic unused_reuse;
  assign unused_reuse = reuse_weights_i;
  assign go_feed      = 1'b0;
`endif

  assign feed_last = T_W'(feed_len(ARRAY_SIZE, int'(m_q)) - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    case (state_q)
      S_IDLE: if (start_i && (num_rows_i != '0)) begin
        m_d     = (num_rows_i > CNT_W'(MAX_ROWS)) ? CNT_W'(MAX_ROWS) : num_rows_i;
        cnt_d   = '0;
        state_d = go_feed ? S_FEED : S_LOAD_W;
      end
      S_LOAD_W: begin
        if (cnt_q == T_W'(LOAD_LEN - 1)) begin
          cnt_d   = '0;
          state_d = S_FEED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FEED: begin
        if (cnt_q == feed_last) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lane decode runs on next-state values so the registered outputs line up with the state.
  logic [ARRAY_SIZE-1:0]            in_en_raw, out_en_raw;
  logic [ARRAY_SIZE-1:0][ROW_W-1:0] in_addr_raw, out_addr_raw;
  logic                             feed_d, load_d;

  assign feed_d = (state_d == S_FEED);
  assign load_d = (state_d == S_LOAD_W);

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    sys_array_skew_gen #(.OFFSET(i), .T_W(T_W), .CNT_W(CNT_W), .ROW_W(ROW_W)) u_in (
      .t_i(cnt_d), .m_i(m_d), .en_o(in_en_raw[i]), .addr_o(in_addr_raw[i])
    );
    sys_array_skew_gen #(.OFFSET(ARRAY_SIZE + i), .T_W(T_W), .CNT_W(CNT_W), .ROW_W(ROW_W)) u_out (
      .t_i(cnt_d), .m_i(m_d), .en_o(out_en_raw[i]), .addr_o(out_addr_raw[i])
    );
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      m_q              <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      weight_load_o    <= '0;
      weight_rd_addr_o <= '0;
      in_row_en_o      <= '0;
      in_rd_addr_o     <= '0;
      out_col_valid_o  <= '0;
      out_wr_addr_o    <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      m_q              <= m_d;
      busy_o           <= (state_d != S_IDLE);
      done_o           <= (state_d == S_DONE);
      weight_load_o    <= load_d ? (ARRAY_SIZE'(1) << cnt_d) : '0;
      weight_rd_addr_o <= load_d ? WA_W'(cnt_d) : '0;
      in_row_en_o      <= feed_d ? in_en_raw : '0;
      in_rd_addr_o     <= feed_d ? in_addr_raw : '0;
      out_col_valid_o  <= feed_d ? out_en_raw : '0;
      out_wr_addr_o    <= feed_d ? out_addr_raw : '0;
    end
  end

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Directed bench for sys_array_ctrl with a behavioural 4x4 weight-stationary array and buffers.
module tb_sys_array_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  num_rows = '0;
  logic        reuse_weights = 1'b0;
  logic        busy, done;
  logic [3:0]  wl, ren, cv;
  logic [1:0]  wra;
  logic [15:0] ra, wa;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sys_array_ctrl #(.ARRAY_SIZE(4), .DATA_WIDTH(8), .MAX_ROWS(16)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .num_rows_i(num_rows),
    .reuse_weights_i(reuse_weights), .busy_o(busy), .done_o(done),
    .weight_load_o(wl), .weight_rd_addr_o(wra), .in_row_en_o(ren), .in_rd_addr_o(ra),
    .out_col_valid_o(cv), .out_wr_addr_o(wa)
  );

  logic [47:0] outs;
  assign outs = {busy, done, wl, wra, ren, ra, cv, wa};

  // Behavioural array: inputs move right, partial sums move down, one cycle per cell.
  logic [7:0]  wbuf [4][4];
  logic [7:0]  ibuf [16][4];
  logic [15:0] rbuf [16][4];
  logic [3:0][3:0][7:0]  w_q, a_q, a_in;
  logic [3:0][3:0][15:0] p_q, p_in;

  always_comb begin
    a_in = '0;
    p_in = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (c == 0) a_in[r][c] = ren[r] ? ibuf[ra[r*4 +: 4]][r] : 8'd0;
        else        a_in[r][c] = a_q[r][(c == 0) ? 0 : c - 1];
        if (r != 0) p_in[r][c] = p_q[(r == 0) ? 0 : r - 1][c];
      end
  end

  always @(posedge clk) begin
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (wl[r]) w_q[r][c] <= wbuf[wra][c];
        a_q[r][c] <= a_in[r][c];
        p_q[r][c] <= p_in[r][c] + w_q[r][c] * a_in[r][c];
      end
    for (int j = 0; j < 4; j++) begin
      if (reset) begin
        for (int m = 0; m < 16; m++) rbuf[m][j] <= 16'hFFFF;
      end else if (cv[j]) begin
        rbuf[wa[j*4 +: 4]][j] <= p_q[3][j];
      end
    end
  end

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [3:0]  wl_tr [64], ren_tr [64], cv_tr [64];
  logic [1:0]  wra_tr [64];
  logic [15:0] ra_tr [64], wa_tr [64];
  logic        bz_tr [64];

  // Called just after a negedge in IDLE; that cycle is cycle 0. inj_cyc re-asserts start there.
  task automatic run_job(input int m, input bit reuse, input int inj_cyc,
                         output int done_cyc, output int n_done);
    num_rows = 5'(m);
    reuse_weights = reuse;
    start = 1'b1;
    done_cyc = -1;
    n_done = 0;
    for (int c = 1; c < 64; c++) begin
      @(negedge clk);
      wl_tr[c] = wl; wra_tr[c] = wra; ren_tr[c] = ren; ra_tr[c] = ra;
      cv_tr[c] = cv; wa_tr[c] = wa; bz_tr[c] = busy;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      start = (c == inj_cyc);
      if (c == inj_cyc) num_rows = 5'd5;
      if (done_cyc >= 0 && c == done_cyc + 1) break;
    end
    start = 1'b0;
  endtask

  int dc, nd;
  logic [3:0] wl_or;
  logic [3:0] wl_exp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [15:0] res_exp [3] = '{16'd10, 16'd8, 16'd5};

  initial begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) wbuf[r][c] = 8'd1;
      for (int m = 0; m < 16; m++) ibuf[m][r] = 8'd0;
      ibuf[0][r] = 8'(r + 1);
      ibuf[1][r] = 8'd2;
    end
    ibuf[2][3] = 8'd5;

    // Reset held while start toggles.
    num_rows = 5'd3;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = c[0];
      chk($sformatf("rst_outs%0d", c), outs, 48'd0);
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // M=3: timing, skew and end-to-end results.
    run_job(3, 1'b0, 0, dc, nd);
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("wl_c%0d", c), wl_tr[c], wl_exp[c-1]);
      chk($sformatf("wra_c%0d", c), wra_tr[c], 48'(c - 1));
    end
    chk("wl_c5", wl_tr[5], 48'd0);
    chk("ren2_c6", ren_tr[6][2], 48'd0);
    chk("ren2_c10", ren_tr[10][2], 48'd0);
    chk("cv3_c11", cv_tr[11][3], 48'd0);
    chk("cv3_c15", cv_tr[15][3], 48'd0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ren2_c%0d", 7 + k), ren_tr[7+k][2], 48'd1);
      chk($sformatf("ra2_c%0d", 7 + k), ra_tr[7+k][11:8], 48'(k));
      chk($sformatf("cv3_c%0d", 12 + k), cv_tr[12+k][3], 48'd1);
      chk($sformatf("wa3_c%0d", 12 + k), wa_tr[12+k][15:12], 48'(k));
    end
    chk("done_cyc_m3", 48'(dc), 48'd15);
    chk("n_done_m3", 48'(nd), 48'd1);
    chk("busy_c1", bz_tr[1], 48'd1);
    chk("busy_c15", bz_tr[15], 48'd1);
    chk("busy_c16", bz_tr[16], 48'd0);
    for (int m = 0; m < 3; m++)
      for (int j = 0; j < 4; j++)
        chk($sformatf("res_m%0d_c%0d", m, j), rbuf[m][j], res_exp[m]);

    // Back-to-back start with a stray start during FEED.
    run_job(3, 1'b0, 8, dc, nd);
    chk("done_cyc_inj", 48'(dc), 48'd15);
    chk("n_done_inj", 48'(nd), 48'd1);

    // num_rows=0 in IDLE is ignored.
    num_rows = 5'd0;
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("zero_busy%0d", c), {busy, done}, 48'd0);
    end
    run_job(3, 1'b0, 0, dc, nd);
    chk("done_cyc_after_zero", 48'(dc), 48'd15);

    // Clamp and minimum length.
    run_job(20, 1'b0, 0, dc, nd);
    chk("done_cyc_clamp", 48'(dc), 48'd28);
    chk("ren0_c20", ren_tr[20][0], 48'd1);
    chk("ra0_c20", ra_tr[20][3:0], 48'd15);
    chk("ren0_c21", ren_tr[21][0], 48'd0);
    run_job(1, 1'b0, 0, dc, nd);
    chk("done_cyc_m1", 48'(dc), 48'd13);

    // Reset mid-FEED at t=3 (cycle 8).
    num_rows = 5'd3;
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("ren_t3", ren, 48'b1110);
    reset = 1'b1;
    #1;
    chk("rst_async_outs", outs, 48'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst_hold%0d", c), outs, 48'd0);
    end
    reset = 1'b0;
    run_job(1, 1'b0, 0, dc, nd);
    chk("done_cyc_post_rst", 48'(dc), 48'd13);

    // Weight reuse request.
    run_job(2, 1'b1, 0, dc, nd);
    wl_or = '0;
    for (int c = 1; c <= 11 && c < 64; c++) wl_or |= wl_tr[c];
`ifdef SYS_ARRAY_CTRL_WEIGHT_REUSE_EN
    chk("reuse_done_cyc", 48'(dc), 48'd10);
    chk("reuse_wl_never", wl_or, 48'd0);
    chk("reuse_ren0_c1", ren_tr[1][0], 48'd1);
    chk("reuse_ren0_c2", ren_tr[2][0], 48'd1);
    chk("reuse_ren0_c3", ren_tr[3][0], 48'd0);
`else
    chk("noreuse_done_cyc", 48'(dc), 48'd14);
    chk("noreuse_wl_c1", wl_tr[1], 48'b0001);
    chk("noreuse_wl_any", wl_or, 48'b1111);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
